// File: rtl/bit_frame_rx_pkg.sv
// Shared types and frame constants for the bit_frame_rx serial receiver.
package bit_frame_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/bit_frame_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/bit_frame_rx.sv
// Oversampling serial frame receiver (start, DATA_W bits LSB first, stop) with a
// one-word valid/ready output buffer, framing-error and overrun pulses.
module bit_frame_rx
    import bit_frame_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    input  logic              ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_line_d;
    logic              w_line;
    logic              w_accept;

    bit_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (serial_in),
        .o_q (w_line)
    );

    assign w_accept = valid & ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_line_d  <= 1'b1;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_line_d  <= w_line;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (w_accept)
                valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    // Only a true high-to-low transition starts a frame
                    if (r_line_d && !w_line) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt   <= '0;
                        r_state <= (w_line == START_BIT) ? DATA : IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= (r_shift >> 1) | (DATA_W'(w_line) << (DATA_W - 1));
                        r_bit   <= r_bit + BIT_W'(1);
                        if (r_bit == BIT_LAST)
                            r_state <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (w_line == STOP_BIT) begin
                            // Buffer is free if empty or being drained this very cycle
                            if (!valid || ready) begin
                                data  <= r_shift;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_frame_rx.sv
// Scoreboard bench for bit_frame_rx: a frame-level model queues expected words and
// pulse counts; a negedge monitor pops and compares on every handshake.
module tb_bit_frame_rx;

    localparam int CPB = 4;
    localparam int DW  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          serial_in;
    logic          ready;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          overrun;

    bit_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] exp_q[$];
    int            ferr_exp = 0;
    int            ferr_cnt = 0;
    int            ovr_exp  = 0;
    int            ovr_cnt  = 0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // Monitor: pop one expected word per accepted handshake, count pulse cycles
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid && prev_hold)
                    chk("hold_stable", 32'(data), 32'(prev_data));
                if (valid && ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h want none", data);
                    end else begin
                        chk("word", 32'(data), 32'(exp_q.pop_front()));
                    end
                end
                if (frame_err) ferr_cnt++;
                if (overrun)   ovr_cnt++;
                prev_hold = valid && !ready;
                prev_data = data;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame starting at posedge+1; the model decides the outcome from
    // the stop bit and whether the consumer's single-word buffer is free.
    task automatic send_frame(input logic [DW-1:0] w, input logic stop, input logic ready_end);
        serial_in = 1'b0;
        idle(CPB);
        for (int i = 0; i < DW; i++) begin
            serial_in = w[i];
            idle(CPB);
        end
        serial_in = stop;
        idle(CPB);
        ready = ready_end;
        if (stop) begin
            serial_in = 1'b1;
            if (ready_end || exp_q.size() == 0) exp_q.push_back(w);
            else ovr_exp++;
        end else begin
            ferr_exp++;
        end
    endtask

    task automatic check_end(input string name);
        chk({name, "_ferr"}, 32'(ferr_cnt), 32'(ferr_exp));
        chk({name, "_ovr"}, 32'(ovr_cnt), 32'(ovr_exp));
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    logic [DW-1:0] rw;
    logic          rstop;
    logic [DW-1:0] part_w;

    initial begin : stim
        rst       = 1'b1;
        serial_in = 1'b1;
        ready     = 1'b0;
        idle(3);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        idle(3);

        // Single good frame, consumer always ready
        ready = 1'b1;
        send_frame(5'h15, 1'b1, 1'b1);
        idle(10);
        check_end("single");

        // One-cycle glitch must be rejected, then a normal frame
        serial_in = 1'b0;
        idle(1);
        serial_in = 1'b1;
        idle(20);
        check_end("glitch");
        send_frame(5'h0A, 1'b1, 1'b1);
        idle(10);
        check_end("after_glitch");

        // Bad stop bit, line held low afterwards must not restart a frame
        send_frame(5'h1F, 1'b0, 1'b1);
        idle(40);
        serial_in = 1'b1;
        idle(10);
        check_end("stop_err");

        // Back-to-back frames with no consumer: second one is an overrun
        ready = 1'b0;
        send_frame(5'h03, 1'b1, 1'b0);
        send_frame(5'h1C, 1'b1, 1'b0);
        idle(5);
        chk("ovr_valid", 32'(valid), 32'd1);
        chk("ovr_data", 32'(data), 32'(exp_q[0]));
        chk("ovr_count", 32'(ovr_cnt), 32'(ovr_exp));
        ready = 1'b1;
        idle(5);
        check_end("overrun");

        // Ready rises in the cycle the second word lands: valid never drops
        ready = 1'b0;
        send_frame(5'h07, 1'b1, 1'b0);
        send_frame(5'h19, 1'b1, 1'b1);
        @(negedge clk);
        chk("swap_valid_a", 32'(valid), 32'd1);
        @(negedge clk);
        chk("swap_valid_b", 32'(valid), 32'd1);
        chk("swap_data", 32'(data), 32'h19);
        idle(5);
        check_end("swap");

        // Reset mid-frame with a word held, then a clean frame
        ready = 1'b0;
        send_frame(5'h06, 1'b1, 1'b0);
        idle(3);
        part_w = 5'h11;
        serial_in = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            serial_in = part_w[i];
            idle(CPB);
        end
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_data", 32'(data), 32'd0);
        chk("mid_rst_ferr", 32'(frame_err), 32'd0);
        chk("mid_rst_ovr", 32'(overrun), 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        serial_in = 1'b1;
        idle(10);
        ready = 1'b1;
        send_frame(5'h11, 1'b1, 1'b1);
        idle(10);
        check_end("post_rst");

        // Randomized frames, stop errors and glitches
        for (int n = 0; n < 24; n++) begin
            rw    = DW'($urandom);
            rstop = ($urandom_range(0, 4) != 0);
            send_frame(rw, rstop, 1'b1);
            serial_in = 1'b1;
            idle($urandom_range(1, 5));
            if ($urandom_range(0, 3) == 0) begin
                serial_in = 1'b0;
                idle(1);
                serial_in = 1'b1;
                idle(12);
            end
        end
        idle(10);
        check_end("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
